// File: rtl/register_file_mp_if.sv
// Bus bundle for register_file_mp: read/write ports, scoreboard set, bulk-clear control.
// Optional par_err signal exists only when RF_PARITY_EN is defined.
interface register_file_mp_if #(
    parameter int DATA_W = 48,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 2
);
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_pending;
    logic [NUM_WR-1:0]        wr_en;
    logic [NUM_WR*ADDR_W-1:0] wr_addr;
    logic [NUM_WR*DATA_W-1:0] wr_data;
    logic                     sb_set_en;
    logic [ADDR_W-1:0]        sb_set_addr;
    logic                     clr_req;
    logic                     clr_busy;
    logic                     clr_done;
`ifdef RF_PARITY_EN
    logic [NUM_RD-1:0]        par_err;
`endif

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, sb_set_en, sb_set_addr, clr_req,
        input  rd_data, rd_pending, clr_busy, clr_done
`ifdef RF_PARITY_EN
        , input par_err
`endif
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, sb_set_en, sb_set_addr, clr_req,
        output rd_data, rd_pending, clr_busy, clr_done
`ifdef RF_PARITY_EN
        , output par_err
`endif
    );
endinterface

// File: rtl/register_file_mp.sv
// Multi-port register file with write-to-read bypass, pending-bit scoreboard and bulk-clear sweep.
// Optional per-register even parity enabled by the RF_PARITY_EN macro.
module register_file_mp #(
    parameter int DATA_W   = 48,
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    register_file_mp_if.slave    bus
);
    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_CLEAR = 1'b1} state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);
    localparam logic [ADDR_W-1:0] ZERO_ADDR = '0;

    state_t              state_r, state_s;
    logic [ADDR_W-1:0]   cnt_r, cnt_s;
    logic                busy_s, done_s;
    logic                clr_busy_r, clr_done_r;
    logic [DATA_W-1:0]   regs_r [NUM_REGS];
    logic [NUM_REGS-1:0] pending_r;
    logic [NUM_RD*DATA_W-1:0] rd_data_s;
    logic [NUM_RD-1:0]   rd_pending_s;
`ifdef RF_PARITY_EN
    logic                par_r [NUM_REGS];
    logic [NUM_RD-1:0]   par_err_s;

    function automatic logic calc_par(input logic [DATA_W-1:0] d);
        return ^d;
    endfunction
`endif

    // Next-state and registered-output decode for the clear sweep
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.clr_req) begin
                    state_s = ST_CLEAR;
                    cnt_s   = ADDR_W'(1);
                end else begin
                    cnt_s   = ZERO_ADDR;
                end
            end
            ST_CLEAR: begin
                if (cnt_r == LAST_ADDR) begin
                    state_s = ST_IDLE;
                    cnt_s   = ZERO_ADDR;
                end else begin
                    cnt_s   = cnt_r + ADDR_W'(1);
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = ZERO_ADDR;
            end
        endcase
        busy_s = (state_s == ST_CLEAR);
        done_s = (state_s == ST_CLEAR) && (cnt_s == LAST_ADDR);
    end

    // FSM state, sweep counter and status flags
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= ST_IDLE;
            cnt_r      <= '0;
            clr_busy_r <= 1'b0;
            clr_done_r <= 1'b0;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            clr_busy_r <= busy_s;
            clr_done_r <= done_s;
        end
    end

    // Register array and scoreboard; later assignments win, so higher ports and set-over-clear take priority
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= '0;
`ifdef RF_PARITY_EN
                par_r[i]  <= 1'b0;
`endif
            end
            pending_r <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    for (int j = 0; j < NUM_WR; j++) begin
                        if (bus.wr_en[j] && (bus.wr_addr[j*ADDR_W +: ADDR_W] != ZERO_ADDR)) begin
                            regs_r[bus.wr_addr[j*ADDR_W +: ADDR_W]]    <= bus.wr_data[j*DATA_W +: DATA_W];
                            pending_r[bus.wr_addr[j*ADDR_W +: ADDR_W]] <= 1'b0;
`ifdef RF_PARITY_EN
                            par_r[bus.wr_addr[j*ADDR_W +: ADDR_W]] <= calc_par(bus.wr_data[j*DATA_W +: DATA_W]);
`endif
                        end
                    end
                    if (bus.sb_set_en && (bus.sb_set_addr != ZERO_ADDR)) begin
                        pending_r[bus.sb_set_addr] <= 1'b1;
                    end
                    if (bus.clr_req) begin
                        pending_r <= '0;
                    end
                end
                ST_CLEAR: begin
                    regs_r[cnt_r] <= '0;
`ifdef RF_PARITY_EN
                    par_r[cnt_r]  <= 1'b0;
`endif
                end
                default: begin
                    pending_r <= '0;
                end
            endcase
        end
    end

    // Combinational read ports with same-cycle bypass and pending masking
    always_comb begin
        rd_data_s    = '0;
        rd_pending_s = '0;
`ifdef RF_PARITY_EN
        par_err_s    = '0;
`endif
        for (int k = 0; k < NUM_RD; k++) begin
            logic [ADDR_W-1:0] a;
            logic              hit;
            logic [DATA_W-1:0] byp;
            a   = bus.rd_addr[k*ADDR_W +: ADDR_W];
            hit = 1'b0;
            byp = '0;
            for (int j = 0; j < NUM_WR; j++) begin
                if (bus.wr_en[j] && (bus.wr_addr[j*ADDR_W +: ADDR_W] == a)) begin
                    hit = 1'b1;
                    byp = bus.wr_data[j*DATA_W +: DATA_W];
                end else begin
                    hit = hit;
                end
            end
            if ((state_r == ST_CLEAR) || (a == ZERO_ADDR)) begin
                rd_data_s[k*DATA_W +: DATA_W] = '0;
                rd_pending_s[k]               = 1'b0;
            end else if (hit) begin
                rd_data_s[k*DATA_W +: DATA_W] = byp;
                rd_pending_s[k]               = 1'b0;
            end else begin
                rd_data_s[k*DATA_W +: DATA_W] = regs_r[a];
                rd_pending_s[k]               = pending_r[a];
`ifdef RF_PARITY_EN
                par_err_s[k]                  = calc_par(regs_r[a]) ^ par_r[a];
`endif
            end
        end
    end

    assign bus.rd_data    = rd_data_s;
    assign bus.rd_pending = rd_pending_s;
    assign bus.clr_busy   = clr_busy_r;
    assign bus.clr_done   = clr_done_r;
`ifdef RF_PARITY_EN
    assign bus.par_err    = par_err_s;
`endif
endmodule
